// File: rtl/pipe_defs.sv
// pipe_defs: shared pipeline constants and instruction field extractors for the MIPS core.
package pipe_defs;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC4 = 32'h0000_3004;
  function automatic logic [5:0] op(input logic [31:0] ir);
    return ir[31:26];
  endfunction
  function automatic logic [5:0] func(input logic [31:0] ir);
    return ir[5:0];
  endfunction
  function automatic logic [4:0] rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction
  function automatic logic [4:0] rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction
  function automatic logic [4:0] rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction
endpackage

// File: rtl/stage_reg.sv
// stage_reg: IR+PC4 pipeline stage register with async reset, hold (en) and bubble insert (clr).
module stage_reg #(
  parameter logic [31:0] RESET_PC4 = pipe_defs::RESET_PC4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc4_o
);
  import pipe_defs::*;
  logic [31:0] ir_q, ir_d, pc4_q, pc4_d;
  // A bubble still takes the incoming PC4 so it stays traceable downstream.
  always_comb begin
    ir_d  = clr_i ? NOP_INSTR : en_i ? ir_i : ir_q;
    pc4_d = (en_i | clr_i) ? pc4_i : pc4_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir_q  <= NOP_INSTR;
      pc4_q <= RESET_PC4;
    end else begin
      ir_q  <= ir_d;
      pc4_q <= pc4_d;
    end
  assign ir_o  = ir_q;
  assign pc4_o = pc4_q;
endmodule

// File: rtl/pipe_regs_fdemw.sv
// pipe_regs_fdemw: F/D/E/M/W pipeline registers with stall bubbling, stall-run watchdog and
// an optional stall-cycle counter built when PIPE_STALL_CNT_EN is defined.
module pipe_regs_fdemw #(
  parameter logic [31:0] RESET_PC4 = pipe_defs::RESET_PC4,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] IR_F,
  input  logic [31:0] PC4_F,
  output logic        en_pc,
  output logic [31:0] IR_D,
  output logic [31:0] IR_E,
  output logic [31:0] IR_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC4_D,
  output logic [31:0] PC4_E,
  output logic [31:0] PC4_M,
  output logic [31:0] PC4_W,
  output logic        hang,
  output logic [31:0] stall_cnt
);
  import pipe_defs::*;
  localparam logic [2:0] RUN_MAX = 3'(MAX_STALL + 1);
  logic [2:0] run_q, run_d;
  logic       hang_q, hang_d;
  assign en_pc = ~stall;
  stage_reg #(.RESET_PC4(RESET_PC4)) u_d (.clk(clk), .reset(reset), .en_i(~stall), .clr_i(1'b0),
    .ir_i(IR_F), .pc4_i(PC4_F), .ir_o(IR_D), .pc4_o(PC4_D));
  stage_reg #(.RESET_PC4(RESET_PC4)) u_e (.clk(clk), .reset(reset), .en_i(1'b1), .clr_i(stall),
    .ir_i(IR_D), .pc4_i(PC4_D), .ir_o(IR_E), .pc4_o(PC4_E));
  stage_reg #(.RESET_PC4(RESET_PC4)) u_m (.clk(clk), .reset(reset), .en_i(1'b1), .clr_i(1'b0),
    .ir_i(IR_E), .pc4_i(PC4_E), .ir_o(IR_M), .pc4_o(PC4_M));
  stage_reg #(.RESET_PC4(RESET_PC4)) u_w (.clk(clk), .reset(reset), .en_i(1'b1), .clr_i(1'b0),
    .ir_i(IR_M), .pc4_i(PC4_M), .ir_o(IR_W), .pc4_o(PC4_W));
  // Run length saturates one past the legal limit; reaching it latches hang.
  always_comb begin
    run_d  = stall ? ((run_q == RUN_MAX) ? run_q : run_q + 3'd1) : 3'd0;
    hang_d = hang_q | (run_d == RUN_MAX);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      run_q  <= 3'd0;
      hang_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      hang_q <= hang_d;
    end
  assign hang = hang_q;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + {31'd0, stall};
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_regs_fdemw.sv
// tb_pipe_regs_fdemw: directed and random stimulus against a stage-array reference model.
module tb_pipe_regs_fdemw;
  localparam int MAX_STALL = 2;
  localparam logic [31:0] RST_PC4 = 32'h0000_3004;
  logic clk = 1'b0, reset, stall;
  logic [31:0] IR_F, PC4_F;
  logic en_pc, hang;
  logic [31:0] IR_D, IR_E, IR_M, IR_W, PC4_D, PC4_E, PC4_M, PC4_W, stall_cnt;
  int vectors = 0, errors = 0;
  logic [31:0] mi[4], mp[4];
  int run;
  logic mh;
  logic [31:0] mc;
  always #5 clk = ~clk;
  pipe_regs_fdemw #(.RESET_PC4(RST_PC4), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset), .stall(stall), .IR_F(IR_F), .PC4_F(PC4_F), .en_pc(en_pc),
    .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M), .IR_W(IR_W),
    .PC4_D(PC4_D), .PC4_E(PC4_E), .PC4_M(PC4_M), .PC4_W(PC4_W),
    .hang(hang), .stall_cnt(stall_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mi[i] = 32'h0;
      mp[i] = RST_PC4;
    end
    run = 0;
    mh = 1'b0;
    mc = 32'h0;
  endtask
  // Index 0..3 = D,E,M,W. A stall holds D, drops a bubble into E carrying D's PC4.
  task automatic model_edge();
    if (stall) begin
      mi[3] = mi[2]; mp[3] = mp[2];
      mi[2] = mi[1]; mp[2] = mp[1];
      mi[1] = 32'h0; mp[1] = mp[0];
      run++;
      mc++;
    end else begin
      for (int i = 3; i > 0; i--) begin
        mi[i] = mi[i-1];
        mp[i] = mp[i-1];
      end
      mi[0] = IR_F;
      mp[0] = PC4_F;
      run = 0;
    end
    if (run > MAX_STALL) mh = 1'b1;
  endtask
  function automatic logic [31:0] cnt_exp();
`ifdef PIPE_STALL_CNT_EN
    return mc;
`else
    return 32'h0;
`endif
  endfunction
  task automatic check_all();
    chk("IR_D", IR_D, mi[0]);
    chk("IR_E", IR_E, mi[1]);
    chk("IR_M", IR_M, mi[2]);
    chk("IR_W", IR_W, mi[3]);
    chk("PC4_D", PC4_D, mp[0]);
    chk("PC4_E", PC4_E, mp[1]);
    chk("PC4_M", PC4_M, mp[2]);
    chk("PC4_W", PC4_W, mp[3]);
    chk("hang", {31'd0, hang}, {31'd0, mh});
    chk("stall_cnt", stall_cnt, cnt_exp());
  endtask
  task automatic step(input logic [31:0] ir, input logic [31:0] pc, input logic st);
    IR_F = ir;
    PC4_F = pc;
    stall = st;
    #1 chk("en_pc", {31'd0, en_pc}, {31'd0, ~st});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  // Called at a falling edge: reset asserts mid-cycle and is checked before any rising edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("en_pc_rst", {31'd0, en_pc}, {31'd0, ~stall});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask
  initial begin
    logic [31:0] pc;
    logic st;
    reset = 1'b1;
    stall = 1'b0;
    IR_F = 32'h0;
    PC4_F = 32'h0;
    model_reset();
    #3 check_all();
    @(negedge clk);
    reset = 1'b0;
    step(32'h8C01_0000, 32'h0000_3004, 1'b0);
    step(32'h0022_1821, 32'h0000_3008, 1'b0);
    step(32'h3443_0001, 32'h0000_300C, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0000_3010 + 32'(4 * i), 1'b0);
    chk("IR_W_flow", IR_W, 32'h3443_0001);
    step(32'h8C01_0000, 32'h0000_3004, 1'b0);
    step(32'h0022_1821, 32'h0000_3008, 1'b0);
    step(32'h3443_0001, 32'h0000_300C, 1'b1);
    chk("IR_D_hold", IR_D, 32'h0022_1821);
    chk("PC4_E_bubble", PC4_E, 32'h0000_3008);
    step(32'h3443_0001, 32'h0000_300C, 1'b0);
    step(32'h8C01_0000, 32'h0000_3010, 1'b0);
    step(32'h1022_0003, 32'h0000_3014, 1'b0);
    step(32'h0, 32'h0000_3018, 1'b1);
    step(32'h0, 32'h0000_3018, 1'b1);
    step(32'h0, 32'h0000_3018, 1'b0);
    chk("hang_lwbeq", {31'd0, hang}, 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) step(32'h1234_5678, 32'h0000_3008, 1'b1);
    chk("hang_wd", {31'd0, hang}, 32'd1);
    step(32'h1234_5678, 32'h0000_3008, 1'b0);
    step(32'h0, 32'h0000_300C, 1'b0);
    chk("hang_sticky", {31'd0, hang}, 32'd1);
    do_reset();
    step(32'hCAFE_0001, 32'h0000_3004, 1'b0);
    step(32'hCAFE_0002, 32'h0000_3008, 1'b1);
    do_reset();
    step(32'hDEAD_BEEF, 32'h0000_4000, 1'b0);
    chk("IR_D_after_rst", IR_D, 32'hDEAD_BEEF);
    pc = 32'h0000_3004;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 2) == 0);
      step($urandom, pc, st);
      if (!st) pc += 32'd4;
      if ($urandom_range(0, 79) == 0) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pipe_regs_fdemw.md
# pipe_regs_fdemw

Pipeline register bank for the five-stage MIPS core: it carries the instruction word and PC+4 from fetch through D, E, M and W. It consumes the `stall` output of the hazard unit: on stall it freezes F/D and injects a NOP bubble into E. It also supplies the `IR_D`/`IR_E`/`IR_M` words that the hazard unit decodes, which closes the loop. It adds a stall-run watchdog and an optional stall-cycle counter.

## Interface
Parameters:
- `RESET_PC4`, 32'h0000_3004: PC+4 value loaded into every stage on reset.
- `MAX_STALL`, 2: longest legal run of consecutive stall cycles. lw→beq needs 2.

Ports:
- `clk`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-high; all state cleared immediately on assertion
- `stall`  in  1  freeze request from the hazard unit, valid before the rising edge
- `IR_F`  in  32  instruction fetched this cycle
- `PC4_F`  in  32  PC+4 of `IR_F`
- `en_pc`  out  1  PC write enable to fetch, combinational `~stall`
- `IR_D`, `IR_E`, `IR_M`, `IR_W`  out  32 each  stage instruction registers
- `PC4_D`, `PC4_E`, `PC4_M`, `PC4_W`  out  32 each  stage PC+4 registers
- `hang`  out  1  sticky watchdog flag
- `stall_cnt`  out  32  stall-cycle count; 0 when the counter is compiled out

## Operation
- NOP encoding is 32'h0000_0000 (`sll $0,$0,0`). The hazard unit classes it as no-hazard.
- Normal cycle (`stall`=0):
  - D←F, E←D, M←E, W←M for both IR and PC4.
- Stall cycle (`stall`=1):
  - `IR_D`/`PC4_D` hold.
  - `IR_E` ← 0; `PC4_E` ← `PC4_D`, so the bubble keeps a traceable PC.
  - M and W advance normally.
  - `en_pc`=0, so fetch re-presents the same `IR_F`.
- Branch delay slot: there is no flush input. The delay-slot instruction always proceeds.
- Watchdog:
  - 3-bit run counter `run`. On each edge with `stall`=1, `run` increments, saturating at `MAX_STALL`+1. On each edge with `stall`=0, `run` clears to 0.
  - `hang` sets on the edge where `run` becomes `MAX_STALL`+1, i.e. the (`MAX_STALL`+1)th consecutive stall cycle.
  - `hang` stays set until `reset`. Pipeline behaviour is unaffected by `hang`.
- Simultaneous events: `stall` is sampled only at the clock edge. Reset has priority over everything.

## Timing
- Reset values:
  - All `IR_*` = 0.
  - All `PC4_*` = `RESET_PC4`.
  - `hang`=0, `run`=0, `stall_cnt`=0.
  - `en_pc` follows `stall` combinationally, including during reset.
- Latency: an instruction presented on `IR_F` appears on `IR_D` one edge later, then `IR_E`/`IR_M`/`IR_W` one edge each after that. A stall adds one cycle per stall cycle to D residency.
- Bubble timing: the bubble is visible on `IR_E` the cycle after the stall edge and reaches `IR_W` two edges later.
- Reset mid-stall: registers clear asynchronously, and the held D instruction is lost. After reset release, with `stall`=0, the next edge loads `IR_F`.
- `stall_cnt` updates on the same edge that samples `stall`=1. It wraps 32'hFFFF_FFFF→0.

## Configuration
- `PIPE_STALL_CNT_EN` defined:
  - 32-bit free-running counter, incremented on each edge with `stall`=1.
  - Reset to 0; wraps on overflow.
- `PIPE_STALL_CNT_EN` undefined: no counter flops are built, and `stall_cnt` is tied to 0.
- The watchdog is always present.

## Structure
- Shared package/header (`pipe_defs`): `NOP_INSTR` = 32'h0, `RESET_PC4` default, and stage field macros `op`, `func`, `rs`, `rt`, `rd` (shared with the hazard unit).
- One natural sub-module, `stage_reg`: a 64-bit IR+PC4 register with async reset, `en` (hold) and `clr` (load NOP, keep PC4 input).
  - Instantiated four times: D uses `en=~stall`; E uses `clr=stall`; M and W are always enabled.
- The watchdog and counter live in the top module.

## Test plan
- **Reset:** assert `reset` mid-cycle → all `IR_*`=0, all `PC4_*`=32'h3004 and `hang`=0 immediately, with no clock edge needed.
- **Free flow:** feed IR 0x8C01_0000, 0x0022_1821, 0x3443_0001 with `stall`=0 → each appears on D/E/M/W on successive edges, with PC4 tracking.
- **Single stall:** `IR_D`=0x0022_1821 with `stall`=1 for one edge →
  - `IR_D` holds.
  - `IR_E`=0 and `PC4_E`=`PC4_D`.
  - `IR_M` takes the old `IR_E`.
  - `en_pc`=0 during the stall.
- **lw→beq:** two consecutive stall cycles → two bubbles enter E, `hang` stays 0, and `stall_cnt`=2 with the macro defined (0 without).
- **Watchdog:** hold `stall`=1 for 3 edges → `hang` rises on the 3rd edge and stays 1 after `stall` drops, until `reset`.
- **Reset mid-stall:** during a stall run of 1, assert `reset` →
  - `run`, `hang` and `stall_cnt` clear.
  - After release with `stall`=0, `IR_F` loads into D on the first edge.
